// File: rtl/tkmc_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package tkmc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=2.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand/result bundle between the pin logic and the serial adder.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             bit_a;
    logic             bit_b;
    logic             bit_s;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  bit_a, bit_b, bit_s, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output bit_a, bit_b, bit_s, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_seq_full_add_bit.sv
// One-bit full adder built from two half-adder stages and an OR on the carries.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_add_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

    // The two half-adder carries can never both be set.
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder controller: one operand bit pair per enabled cycle, LSB first,
// with the carry held in a flop so a single full-adder slice covers WIDTH bits.
module serial_add_seq
    import tkmc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    serial_add_seq_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic fa_s;
    logic fa_c;
    logic in_shift;

    full_add_bit u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_c)
    );

    assign in_shift = (state_q == SHIFT);

    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sr_d  = bus.a;
                        b_sr_d  = bus.b;
                        carry_d = bus.cin;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    res_d   = {fa_s, res_q[WIDTH-1:1]};
                    a_sr_d  = a_sr_q >> 1;
                    b_sr_d  = b_sr_q >> 1;
                    carry_d = fa_c;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_d   = {fa_s, res_q[WIDTH-1:1]};
                        cout_d  = fa_c;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Serial taps are only meaningful while shifting; forced low otherwise.
    assign bus.bit_a = in_shift & a_sr_q[0];
    assign bus.bit_b = in_shift & b_sr_q[0];
    assign bus.bit_s = in_shift & fa_s;
    assign bus.busy  = in_shift;
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed-vector bench for serial_add_seq with hand-computed sums and latencies.
module tb_serial_add_seq;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    logic ena;

    int n_checks;
    int n_pass;

    serial_add_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one add and follow it to completion; optional 3-cycle ena gap and
    // stray starts during SHIFT/DONE.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input int pause_at, input bit poke,
                          input logic [7:0] es, input logic ec);
        int          n;
        int          nbits;
        bit          seen;
        logic [15:0] bits;
        n = 0; nbits = 0; seen = 0; bits = '0;
        bus.a = av; bus.b = bv; bus.cin = ci; bus.start = 1'b1; ena = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        while (!seen && n < 40) begin
            ena = (pause_at >= 0 && n >= pause_at && n < pause_at + 3) ? 1'b0 : 1'b1;
            if (poke && n == 2) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy && ena && nbits < 16) begin
                bits[nbits] = bus.bit_s;
                nbits++;
            end
            tick();
            n++;
            if (bus.done) seen = 1;
        end
        ena = 1'b1;
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(WIDTH + ((pause_at >= 0) ? 3 : 0)));
        check({tag, "_busy_cycles"}, 32'(nbits), 32'(WIDTH));
        check({tag, "_bit_s_seq"}, 32'(bits[7:0]), 32'(es));
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        if (poke) begin
            bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
        end
        tick();
        bus.start = 1'b0;
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        tick();
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_sum_held"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        int done_edges[$];
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; ena = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #2;
        check("rst_outputs", 32'({bus.busy, bus.done, bus.bit_a, bus.bit_b, bus.bit_s, bus.cout}), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 3C+05: bit_s LSB-first 1,0,0,0,0,0,1,0
        run_op("add_3c_05", 8'h3C, 8'h05, 1'b0, -1, 1'b0, 8'h41, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, -1, 1'b0, 8'h00, 1'b1);
        run_op("add_cin",   8'h00, 8'h00, 1'b1, -1, 1'b0, 8'h01, 1'b0);
        run_op("add_pause", 8'hAA, 8'h55, 1'b0,  3, 1'b0, 8'hFF, 1'b0);
        run_op("add_poke",  8'h12, 8'h34, 1'b0, -1, 1'b1, 8'h46, 1'b0);

        // start held high: back-to-back operations
        bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (bus.done) begin
                done_edges.push_back(e);
                check("b2b_sum", 32'(bus.sum), 32'h02);
                check("b2b_cout", 32'(bus.cout), 32'd0);
            end
        end
        bus.start = 1'b0;
        check("b2b_pulses", 32'(done_edges.size() >= 3), 32'd1);
        if (done_edges.size() >= 3) begin
            check("b2b_first", 32'(done_edges[0]), 32'(WIDTH + 1));
            check("b2b_gap1", 32'(done_edges[1] - done_edges[0]), 32'(WIDTH + 2));
            check("b2b_gap2", 32'(done_edges[2] - done_edges[1]), 32'(WIDTH + 2));
        end
        for (int e = 0; e < 12; e++) tick();
        check("b2b_idle", 32'(bus.busy), 32'd0);

        // abort mid-SHIFT with reset
        bus.a = 8'h80; bus.b = 8'h80; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({bus.busy, bus.done, bus.bit_a, bus.bit_b, bus.bit_s, bus.cout}), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        tick();
        rst_n = 1'b1;
        begin
            int saw;
            saw = 0;
            for (int e = 0; e < 12; e++) begin
                tick();
                if (bus.done || bus.busy) saw++;
            end
            check("abort_no_done", 32'(saw), 32'd0);
            check("abort_sum_after", 32'(bus.sum), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
